// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: prescaled digit slots with a leading blank interval,
// a shadow copy of the data refreshed only at frame wrap, and optional leading-zero blanking.
module seg_scan_display #(
   parameter int DIGITS      = 4,
   parameter int PRESCALE    = 8192,
   parameter int BLANK_CYC   = 1,
   parameter int SEG_ACT_LOW = 1,
   parameter int EN_ACT_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_lz,
   input  logic                  hold,
   output logic [6:0]            light,
   output logic                  dp,
   output logic [DIGITS-1:0]     en,
   output logic                  frame_done
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
   localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);
   localparam logic SEG_POL = (SEG_ACT_LOW != 0);
   localparam logic EN_POL  = (EN_ACT_LOW != 0);

   logic [PW-1:0]         pcnt;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   shd;
   logic [DIGITS-1:0]     shd_dp;

   logic                  tick;
   logic                  wrap;
   logic                  zero_run;
   logic [DIGITS-1:0]     lz_mask;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_blank;
   logic                  show;
   logic [DIGITS-1:0]     en_hot;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0:    hex7 = 7'h3F;
         4'h1:    hex7 = 7'h06;
         4'h2:    hex7 = 7'h5B;
         4'h3:    hex7 = 7'h4F;
         4'h4:    hex7 = 7'h66;
         4'h5:    hex7 = 7'h6D;
         4'h6:    hex7 = 7'h7D;
         4'h7:    hex7 = 7'h07;
         4'h8:    hex7 = 7'h7F;
         4'h9:    hex7 = 7'h6F;
         4'hA:    hex7 = 7'h77;
         4'hB:    hex7 = 7'h7C;
         4'hC:    hex7 = 7'h39;
         4'hD:    hex7 = 7'h5E;
         4'hE:    hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign tick = (pcnt == P_LAST);
   assign wrap = tick && (idx == I_LAST);

   // Walk from the top nibble down; a digit is a leading zero while every nibble above it is zero too.
   always_comb begin
      zero_run = 1'b1;
      lz_mask  = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_run   = zero_run & (shd[4*k +: 4] == 4'h0);
         lz_mask[k] = zero_run && (k != 0);
      end
   end

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            cur_nib   = shd[4*k +: 4];
            cur_dp    = shd_dp[k];
            cur_blank = blank_lz & lz_mask[k];
         end
      end
   end

   assign show   = (pcnt >= P_BLANK) && !cur_blank;
   assign en_hot = show ? (DIGITS'(1) << idx) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt       <= '0;
         idx        <= '0;
         shd        <= '0;
         shd_dp     <= '0;
         frame_done <= 1'b0;
         en         <= {DIGITS{EN_POL}};
         light      <= {7{SEG_POL}};
         dp         <= SEG_POL;
      end else begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
         if (tick) begin
            idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
         end
         if (wrap && !hold) begin
            shd    <= data;
            shd_dp <= dp_in;
         end
         frame_done <= wrap;
         en         <= en_hot ^ {DIGITS{EN_POL}};
         light      <= hex7(cur_nib) ^ {7{SEG_POL}};
         dp         <= (show & cur_dp) ^ SEG_POL;
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: constant vector table, hand-written multi-cycle sequences,
// and a random phase checked every cycle against an arithmetic model of the scan.
module tb_seg_scan_display;

   localparam int D  = 4;
   localparam int P  = 4;
   localparam int B  = 1;
   localparam int FR = D * P;

   localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic            clk;
   logic            reset;
   logic [4*D-1:0]  data;
   logic [D-1:0]    dp_in;
   logic            blank_lz;
   logic            hold;
   logic [6:0]      light;
   logic            dp;
   logic [D-1:0]    en;
   logic            frame_done;

   int              checks = 0;
   int              errors = 0;
   int              n = 0;
   int              fd_count = 0;
   logic [15:0]     shd_m = '0;
   logic [3:0]      shdp_m = '0;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dpi;
      logic        blz;
      int          dig;
      int          pc;
      logic [3:0]  en;
      logic [6:0]  seg;
      logic        dpo;
      logic        chk_seg;
   } vec_t;

   vec_t tbl [18];

   seg_scan_display #(
      .DIGITS(D), .PRESCALE(P), .BLANK_CYC(B), .SEG_ACT_LOW(1), .EN_ACT_LOW(1)
   ) dut (
      .clk(clk), .reset(reset), .data(data), .dp_in(dp_in), .blank_lz(blank_lz), .hold(hold),
      .light(light), .dp(dp), .en(en), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (model state %0d)", name, act, exp, n);
      end
   endtask

   // Expected {en, light, dp} for scan state n (cycles since reset), from slot/digit arithmetic.
   function automatic logic [11:0] model_out(int st, logic [15:0] s, logic [3:0] sdp, logic blz);
      int p, d;
      logic [3:0] nib;
      logic blanked, show;
      logic [3:0] e;
      logic [6:0] l;
      logic dd;
      p       = st % P;
      d       = (st / P) % D;
      nib     = 4'((s >> (4*d)) & 16'hF);
      blanked = blz && (d != 0) && ((s >> (4*d)) == 16'h0);
      show    = (p >= B) && !blanked;
      e       = show ? ~(4'b1 << d) : 4'hF;
      l       = ~SEG_TAB[nib];
      dd      = ~(show & sdp[d]);
      return {e, l, dd};
   endfunction

   task automatic step();
      logic [11:0] ex;
      logic        exfd;
      logic        hold_s;
      logic [15:0] data_s;
      logic [3:0]  dpi_s;
      ex     = model_out(n, shd_m, shdp_m, blank_lz);
      exfd   = (n % FR) == (FR - 1);
      hold_s = hold;
      data_s = data;
      dpi_s  = dp_in;
      @(posedge clk);
      #1;
      check("cyc_en", en, ex[11:8]);
      if (ex[11:8] != 4'hF) check("cyc_light", light, ex[7:1]);
      check("cyc_dp", dp, ex[0]);
      check("cyc_frame_done", frame_done, exfd);
      if (exfd && !hold_s) begin
         shd_m  = data_s;
         shdp_m = dpi_s;
      end
      if (frame_done) fd_count++;
      n++;
   endtask

   task automatic run_to(input int target);
      while (n < target) step();
   endtask

   // Called at posedge+1: asserts reset between edges and checks the immediate response.
   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      check("rst_en", en, 4'hF);
      check("rst_light", light, 7'h7F);
      check("rst_dp", dp, 1'b1);
      check("rst_frame_done", frame_done, 1'b0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      n      = 0;
      shd_m  = '0;
      shdp_m = '0;
   endtask

   initial begin
      logic [6:0] el;
      tbl = '{
         '{16'h1234, 4'h0, 1'b0, 0, 0, 4'hF, 7'h00, 1'b1, 1'b0},
         '{16'h1234, 4'h0, 1'b0, 0, 1, 4'hE, 7'h66, 1'b1, 1'b1},
         '{16'h1234, 4'h0, 1'b0, 1, 1, 4'hD, 7'h4F, 1'b1, 1'b1},
         '{16'h1234, 4'h0, 1'b0, 2, 3, 4'hB, 7'h5B, 1'b1, 1'b1},
         '{16'h1234, 4'h0, 1'b0, 3, 2, 4'h7, 7'h06, 1'b1, 1'b1},
         '{16'hABCD, 4'h0, 1'b0, 0, 1, 4'hE, 7'h5E, 1'b1, 1'b1},
         '{16'hABCD, 4'h0, 1'b0, 2, 1, 4'hB, 7'h7C, 1'b1, 1'b1},
         '{16'hABCD, 4'h0, 1'b0, 3, 1, 4'h7, 7'h77, 1'b1, 1'b1},
         '{16'h0050, 4'h0, 1'b1, 3, 2, 4'hF, 7'h00, 1'b1, 1'b0},
         '{16'h0050, 4'h0, 1'b1, 2, 1, 4'hF, 7'h00, 1'b1, 1'b0},
         '{16'h0050, 4'h0, 1'b1, 1, 1, 4'hD, 7'h6D, 1'b1, 1'b1},
         '{16'h0050, 4'h0, 1'b1, 0, 1, 4'hE, 7'h3F, 1'b1, 1'b1},
         '{16'h0000, 4'h0, 1'b1, 1, 1, 4'hF, 7'h00, 1'b1, 1'b0},
         '{16'h0000, 4'h0, 1'b1, 0, 2, 4'hE, 7'h3F, 1'b1, 1'b1},
         '{16'h1234, 4'h4, 1'b0, 2, 1, 4'hB, 7'h5B, 1'b0, 1'b1},
         '{16'h1234, 4'h4, 1'b0, 1, 1, 4'hD, 7'h4F, 1'b1, 1'b1},
         '{16'h1234, 4'h4, 1'b0, 2, 0, 4'hF, 7'h00, 1'b1, 1'b0},
         '{16'h0050, 4'h0, 1'b0, 3, 1, 4'h7, 7'h3F, 1'b1, 1'b1}
      };

      reset    = 1'b1;
      data     = '0;
      dp_in    = '0;
      blank_lz = 1'b0;
      hold     = 1'b0;
      #1;
      check("por_en", en, 4'hF);
      check("por_light", light, 7'h7F);
      @(posedge clk);
      #1;
      reset = 1'b0;
      n     = 0;

      // Vector table: the value loaded at the first wrap is seen in the second frame.
      for (int i = 0; i < 18; i++) begin
         do_reset();
         data     = tbl[i].data;
         dp_in    = tbl[i].dpi;
         blank_lz = tbl[i].blz;
         run_to(FR + P*tbl[i].dig + tbl[i].pc + 1);
         check("tbl_en", en, tbl[i].en);
         el = ~tbl[i].seg;
         if (tbl[i].chk_seg) check("tbl_light", light, el);
         check("tbl_dp", dp, tbl[i].dpo);
      end
      dp_in    = '0;
      blank_lz = 1'b0;

      // Tear-free latch: change at frame cycle 6 stays invisible until the next frame.
      do_reset();
      data = 16'h1234;
      run_to(FR + 6);
      data = 16'hABCD;
      run_to(FR + 14);
      el = ~7'h06;
      check("tear_d3_old", light, el);
      run_to(2*FR + 6);
      el = ~7'h39;
      check("tear_d1_new", light, el);
      run_to(2*FR + 14);
      el = ~7'h77;
      check("tear_d3_new", light, el);

      // Hold across three wraps, then release mid-frame.
      do_reset();
      data = 16'h1234;
      run_to(FR + 4);
      hold     = 1'b1;
      data     = 16'hFFFF;
      fd_count = 0;
      run_to(4*FR + 2);
      check("hold_fd_count", fd_count, 3);
      el = ~7'h66;
      check("hold_light", light, el);
      check("hold_en", en, 4'hE);
      run_to(4*FR + 6);
      hold = 1'b0;
      run_to(5*FR + 2);
      el = ~7'h71;
      check("release_d0", light, el);
      run_to(5*FR + 14);
      check("release_d3", light, el);
      check("release_en", en, 4'h7);

      // Async reset mid-slot: restart at digit 0, shadow cleared until the first wrap.
      do_reset();
      data = 16'h1234;
      run_to(FR + 7);
      do_reset();
      run_to(1);
      check("ar_blank_slot", en, 4'hF);
      run_to(2);
      check("ar_d0_en", en, 4'hE);
      el = ~7'h3F;
      check("ar_d0_zero", light, el);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         data     = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
         dp_in    = 4'($urandom);
         blank_lz = 1'($urandom);
         hold     = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised multiplexed seven-segment display driver that scans up to eight hex digits from a packed data word, with its own refresh prescaler, anti-ghosting blank interval, tear-free frame latching, optional leading-zero blanking and hold. It sits between the CPU debug output (selected register/word `y`) and the board LED pins. It replaces the fixed 4-digit display plus separate display clock divider with one block on the system clock.

## Interface
- `DIGITS`, 4: number of digits scanned, 1..8.
- `PRESCALE`, 8192: clock cycles per digit slot, ≥ 2.
- `BLANK_CYC`, 1: cycles at the start of each slot with all enables inactive, 0 ≤ BLANK_CYC < PRESCALE.
- `SEG_ACT_LOW`, 1: 1 means segments and `dp` are driven active-low.
- `EN_ACT_LOW`, 1: 1 means digit enables are driven active-low.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `data`  in  4*DIGITS  nibble k drives digit k; digit 0 is least significant.
- `dp_in`  in  DIGITS  decimal point request per digit.
- `blank_lz`  in  1  enable leading-zero blanking.
- `hold`  in  1  freeze the displayed value; the end-of-frame latch is suppressed.
- `light`  out  7  segments; bit0 = a … bit6 = g.
- `dp`  out  1  decimal point.
- `en`  out  DIGITS  digit enables, one-hot active or all inactive.
- `frame_done`  out  1  one-cycle pulse at each frame wrap.

## Operation
- Prescaler `pcnt` counts 0..PRESCALE-1 and wraps. `tick` is true when pcnt = PRESCALE-1.
- Digit index `idx` counts 0..DIGITS-1:
  - It advances on `tick`.
  - It wraps from DIGITS-1 to 0. That wrap is the frame wrap.
- Shadow register `shd` (4*DIGITS bits) and `shd_dp` (DIGITS bits):
  - Both load from `data`/`dp_in` on the frame-wrap cycle when `hold` = 0.
  - When `hold` = 1 they keep their value.
  - Mid-frame changes on `data` never reach the outputs.
- Leading-zero blanking (`blank_lz` = 1, evaluated on `shd`):
  - Digit k is blanked if nibbles DIGITS-1 down to k are all zero and k ≠ 0.
  - Digit 0 is never blanked.
  - A blanked digit's slot keeps all enables inactive.
  - `blank_lz` is sampled combinationally each cycle and takes effect on the next output register update.
- Hex decode, active-high values:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - `SEG_ACT_LOW` inverts `light` and `dp`.
- Enable rule: `en` bit idx is active only when pcnt ≥ BLANK_CYC and digit idx is not blanked. Otherwise all enables are inactive.
- `EN_ACT_LOW` inverts all `en` bits.

## Timing
- All outputs are registered and reflect the (pcnt, idx, shd) state of the previous cycle: one-cycle latency.
- Slot length is PRESCALE cycles. Frame length is DIGITS*PRESCALE cycles. Refresh rate is f_clk / (DIGITS*PRESCALE).
- `frame_done`:
  - Rises in the cycle after the frame-wrap edge, i.e. in the same cycle the new `shd` is first visible.
  - High for exactly one cycle.
  - Also pulses when `hold` = 1.
- Reset, asynchronous and immediate:
  - pcnt = 0, idx = 0, shd = 0, shd_dp = 0.
  - `frame_done` = 0.
  - `en` all inactive; `light` and `dp` all segments off at inactive polarity.
- Reset mid-scan aborts the slot; scanning restarts at digit 0, slot cycle 0. The first load of `data` occurs at the end of the first frame after reset.
- `hold` asserted on the frame-wrap cycle blocks that load. `hold` released mid-frame has no effect until the next wrap.
- DIGITS = 1: every tick is a frame wrap, and `en` is a 1-bit vector.

## Test plan
- Scan order, using DIGITS=4, PRESCALE=4, BLANK_CYC=1, active-low outputs:
  - Stimulus: data=16'h1234 applied before the first wrap.
  - Required in the second frame:
    - `en` is 1111 for one cycle, then 1110 for 3 cycles with light=~7'h66.
    - The next slot is 1101 with ~7'h4F, then 1011 with ~7'h5B, then 0111 with ~7'h06.
  - `frame_done` pulses every 16 cycles.
- Tear-free latch: change data from 16'h1234 to 16'hABCD at frame cycle 6.
  - The rest of that frame still shows 1234.
  - The next frame shows ABCD (b=~7'h7C, d=~7'h5E).
- Leading-zero blanking: data=16'h0050, blank_lz=1.
  - Digits 3 and 2 have `en` all-high for their whole slot.
  - Digit 1 shows 5; digit 0 shows 0.
  - data=16'h0000 shows only digit 0 as "0".
- Hold: hold=1 before a wrap, then data=16'hFFFF.
  - The display keeps the old value across 3 frames, and `frame_done` still pulses.
  - Release hold; F (~7'h71) appears on all digits after the next wrap.
- Decimal point: dp_in=4'b0100 gives dp=0 only during the digit-2 enabled cycles.
- Async reset: assert `reset` at a mid-slot cycle with no clock edge.
  - Outputs go inactive immediately.
  - After release, the digit-0 slot begins at pcnt 0, and a 0 is shown until the first wrap.
